vector_lsu_seq: RTL and testbench

- Sequential, parametrised successor to the combinational vector load/store address block.
- On a start command, walks the active lanes of a vector, generating per-lane addresses base + i*stride.
- Issues one memory request per lane over a req/ack handshake, and gathers load data or scatters store data.
- Sits between the vector register file/execute stage and the data memory port of the vector CPU.

---
 rtl/vector_pkg.sv | 38 +++
 rtl/vector_addr_gen.sv | 56 +++++
 rtl/vector_lsu_seq.sv | 153 +++++++++++++++
 tb/tb_vector_lsu_seq.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_pkg.sv
// Shared types and helpers for the sequential vector load/store unit.
package vector_pkg;

   localparam int LANES_DEF  = 4;
   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 32;

   // Widest lane mask the lane-search helper understands.
   localparam int MAX_LANES  = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      FIN  = 2'd2
   } lsu_state_t;

   typedef struct packed {
      logic       found;
      logic [3:0] idx;
   } lane_sel_t;

   // Lowest set bit of mask at or above index 'from'. The loop runs downward,
   // so the last hit it records is the lowest qualifying lane.
   function automatic lane_sel_t next_set_lane(input logic [MAX_LANES-1:0] mask,
                                               input int from);
      lane_sel_t sel;
      sel.found = 1'b0;
      sel.idx   = '0;
      for (int i = MAX_LANES - 1; i >= 0; i--) begin
         if (mask[i] && (i >= from)) begin
            sel.found = 1'b1;
            sel.idx   = 4'(i);
         end
      end
      return sel;
   endfunction

endpackage

// File: rtl/vector_addr_gen.sv
// Address generator: holds the command's base and stride and registers the
// address of the lane about to be requested (base + idx*stride, wrapping).
module vector_addr_gen
   import vector_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int IDX_W  = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_i,
   input  logic              advance_i,
   input  logic [ADDR_W-1:0] base_i,
   input  logic [ADDR_W-1:0] stride_i,
   input  logic [IDX_W-1:0]  laneIdx_i,
   output logic [ADDR_W-1:0] addr_o
);

   logic [ADDR_W-1:0] base_q,   base_d;
   logic [ADDR_W-1:0] stride_q, stride_d;
   logic [ADDR_W-1:0] addr_q,   addr_d;
   logic [ADDR_W-1:0] laneOff;

   // A new command computes its first address straight from the live inputs,
   // so the first request is ready the cycle after start; later lanes use the
   // held base/stride and are computed while the previous lane is acked.
   always_comb begin
      base_d   = base_q;
      stride_d = stride_q;
      addr_d   = addr_q;
      laneOff  = ADDR_W'(laneIdx_i);
      if (load_i) begin
         base_d   = base_i;
         stride_d = stride_i;
         addr_d   = base_i + laneOff * stride_i;
      end else if (advance_i) begin
         addr_d   = base_q + laneOff * stride_q;
      end
   end

   // Address and command registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         base_q   <= '0;
         stride_q <= '0;
         addr_q   <= '0;
      end else begin
         base_q   <= base_d;
         stride_q <= stride_d;
         addr_q   <= addr_d;
      end
   end

   assign addr_o = addr_q;

endmodule

// File: rtl/vector_lsu_seq.sv
// Sequential vector load/store unit: walks the active lanes of a command and
// issues one memory request per lane, gathering loads or scattering stores.
module vector_lsu_seq
   import vector_pkg::*;
#(
   parameter int LANES  = LANES_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic                          is_store,
   input  logic [ADDR_W-1:0]             base_addr,
   input  logic [ADDR_W-1:0]             stride,
   input  logic [LANES-1:0]              lane_mask,
   input  logic [LANES-1:0][DATA_W-1:0]  store_data,
   output logic                          mem_req,
   output logic                          mem_we,
   output logic [ADDR_W-1:0]             mem_addr,
   output logic [DATA_W-1:0]             mem_wdata,
   input  logic                          mem_ack,
   input  logic [DATA_W-1:0]             mem_rdata,
   output logic                          busy,
   output logic                          done,
   output logic [LANES-1:0][DATA_W-1:0]  load_data
);

   localparam int IDX_W = $clog2(LANES);

   lsu_state_t                 state_q, state_d;
   logic [IDX_W-1:0]           idx_q, idx_d;
   logic [LANES-1:0]           mask_q, mask_d;
   logic [LANES-1:0][DATA_W-1:0] storeVec_q, storeVec_d;
   logic                       isStore_q, isStore_d;
   logic                       req_q, we_q, busy_q, done_q;
   logic [DATA_W-1:0]          wdata_q;
   logic [LANES-1:0][DATA_W-1:0] load_q;
   logic                       accept;
   logic                       advance;
   lane_sel_t                  sel;

   // Next-state logic: accept a command in IDLE, step through set mask bits
   // on each ack in REQ, and spend a single cycle in FIN to signal completion.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      mask_d     = mask_q;
      storeVec_d = storeVec_q;
      isStore_d  = isStore_q;
      accept     = 1'b0;
      advance    = 1'b0;
      sel        = '0;
      case (state_q)
         IDLE: begin
            if (start) begin
               accept     = 1'b1;
               mask_d     = lane_mask;
               storeVec_d = store_data;
               isStore_d  = is_store;
               sel        = next_set_lane(MAX_LANES'(lane_mask), 0);
               if (sel.found) begin
                  state_d = REQ;
                  idx_d   = sel.idx[IDX_W-1:0];
               end else begin
                  state_d = FIN;
               end
            end
         end
         REQ: begin
            if (mem_ack) begin
               sel = next_set_lane(MAX_LANES'(mask_q), int'(idx_q) + 1);
               if (sel.found) begin
                  advance = 1'b1;
                  idx_d   = sel.idx[IDX_W-1:0];
               end else begin
                  state_d = FIN;
               end
            end
         end
         FIN: begin
            state_d = IDLE;
            idx_d   = '0;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and registered request outputs; the outputs are derived from the
   // next state so a request appears in the same cycle the FSM enters REQ and
   // stays unchanged while the memory withholds its ack.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         mask_q     <= '0;
         storeVec_q <= '0;
         isStore_q  <= 1'b0;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         wdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         mask_q     <= mask_d;
         storeVec_q <= storeVec_d;
         isStore_q  <= isStore_d;
         req_q      <= (state_d == REQ);
         we_q       <= (state_d == REQ) && isStore_d;
         busy_q     <= (state_d != IDLE);
         done_q     <= (state_d == FIN);
         if (state_d == REQ) begin
            wdata_q <= storeVec_d[idx_d];
         end
      end
   end

   // Gather: each acked load lane captures the returned data; masked lanes
   // and store commands leave the vector untouched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         load_q <= '0;
      end else if ((state_q == REQ) && mem_ack && !isStore_q) begin
         load_q[idx_q] <= mem_rdata;
      end
   end

   vector_addr_gen #(
      .ADDR_W (ADDR_W),
      .IDX_W  (IDX_W)
   ) u_addr_gen (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_i    (accept),
      .advance_i (advance),
      .base_i    (base_addr),
      .stride_i  (stride),
      .laneIdx_i (idx_d),
      .addr_o    (mem_addr)
   );

   assign mem_req   = req_q;
   assign mem_we    = we_q;
   assign mem_wdata = wdata_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign load_data = load_q;

endmodule

// File: tb/tb_vector_lsu_seq.sv
// Bench for vector_lsu_seq: a request-list model plus directed timing pins.
module tb_vector_lsu_seq;

   localparam int LANES  = 4;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 32;

   logic                         clk = 1'b0;
   logic                         rst_n;
   logic                         start;
   logic                         is_store;
   logic [ADDR_W-1:0]            base_addr;
   logic [ADDR_W-1:0]            stride;
   logic [LANES-1:0]             lane_mask;
   logic [LANES-1:0][DATA_W-1:0] store_data;
   logic                         mem_req;
   logic                         mem_we;
   logic [ADDR_W-1:0]            mem_addr;
   logic [DATA_W-1:0]            mem_wdata;
   logic                         mem_ack;
   logic [DATA_W-1:0]            mem_rdata;
   logic                         busy;
   logic                         done;
   logic [LANES-1:0][DATA_W-1:0] load_data;

   vector_lsu_seq #(
      .LANES  (LANES),
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .is_store   (is_store),
      .base_addr  (base_addr),
      .stride     (stride),
      .lane_mask  (lane_mask),
      .store_data (store_data),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata),
      .busy       (busy),
      .done       (done),
      .load_data  (load_data)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
   } reqExp_t;

   int          testsRun  = 0;
   int          failCount = 0;
   reqExp_t     expQ[$];
   logic [31:0] modelLoad [LANES];
   logic [31:0] memImage [logic [31:0]];
   logic [31:0] accAddr [16];
   int          nAcc = 0;
   int          stallOrdinal = -1;
   int          stallLeft = 0;
   int          acksGiven = 0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] memRead(input logic [31:0] a);
      if (memImage.exists(a)) return memImage[a];
      return a ^ 32'hA5A5_0000;
   endfunction

   // Memory responder: answers mid-cycle so the ack is stable before the
   // sampling edge; one chosen request ordinal can be made to wait.
   initial begin
      mem_ack   = 1'b0;
      mem_rdata = '0;
      forever begin
         @(posedge clk);
         #2;
         if (mem_req === 1'b1 && rst_n === 1'b1) begin
            if (acksGiven == stallOrdinal && stallLeft > 0) begin
               mem_ack = 1'b0;
               stallLeft--;
            end else begin
               mem_ack = 1'b1;
               acksGiven++;
            end
            mem_rdata = memRead(mem_addr);
         end else begin
            mem_ack   = 1'b0;
            mem_rdata = '0;
         end
      end
   end

   // Compare process: every request must match the head of the expected
   // request list, and each done pulse must see the expected load vector.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1) begin
            if (expQ.size() > 0) checkOutput("busy_while_pending", 32'(busy), 32'd1);
            if (mem_req === 1'b1) begin
               if (expQ.size() == 0) begin
                  checkOutput("unexpected_req", 32'(mem_req), 32'd0);
               end else begin
                  checkOutput("req_addr", mem_addr, expQ[0].addr);
                  checkOutput("req_we", 32'(mem_we), 32'(expQ[0].we));
                  if (expQ[0].we) checkOutput("req_wdata", mem_wdata, expQ[0].wdata);
                  if (mem_ack === 1'b1) void'(expQ.pop_front());
               end
            end
            if (done === 1'b1) begin
               checkOutput("done_with_pending_reqs", 32'(expQ.size()), 32'd0);
               for (int i = 0; i < LANES; i++)
                  checkOutput($sformatf("load_data[%0d]", i), load_data[i], modelLoad[i]);
            end
         end
      end
   end

   // Issue one command, build its expected request list, then watch it cycle
   // by cycle (cycle 0 = the cycle start is high).
   task automatic applyStimulus(input logic st, input logic [31:0] base, input logic [31:0] strd,
                                input logic [3:0] mask, input logic [3:0][31:0] sdata,
                                input int stallOrd, input int stallCycles,
                                input int extraStartAt, input int resetAt,
                                output int doneCycle, output int reqCycles, output int busyCycles);
      reqExp_t e;
      bit      stopped;
      @(negedge clk);
      start      = 1'b1;
      is_store   = st;
      base_addr  = base;
      stride     = strd;
      lane_mask  = mask;
      store_data = sdata;
      acksGiven    = 0;
      stallOrdinal = stallOrd;
      stallLeft    = stallCycles;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int i = 0; i < LANES; i++) begin
         if (mask[i]) begin
            e.addr  = base + 32'(i) * strd;
            e.we    = st;
            e.wdata = sdata[i];
            expQ.push_back(e);
            if (!st) modelLoad[i] = memRead(e.addr);
         end
      end
      doneCycle  = -1;
      reqCycles  = 0;
      busyCycles = 0;
      nAcc       = 0;
      stopped    = 1'b0;
      for (int k = 1; k <= 40 && !stopped; k++) begin
         @(negedge clk);
         if (mem_req === 1'b1) reqCycles++;
         if (busy === 1'b1) busyCycles++;
         if (mem_req === 1'b1 && mem_ack === 1'b1 && nAcc < 16) begin
            accAddr[nAcc] = mem_addr;
            nAcc++;
         end
         if (k == extraStartAt) begin
            start     = 1'b1;
            lane_mask = 4'b0000;
            base_addr = 32'hDEAD_0000;
            is_store  = ~st;
         end else begin
            start = 1'b0;
         end
         if (k == resetAt) begin
            #1;
            rst_n = 1'b0;
            expQ.delete();
            for (int i = 0; i < LANES; i++) modelLoad[i] = '0;
            #1;
            checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
            checkOutput("rst_busy", 32'(busy), 32'd0);
            checkOutput("rst_done", 32'(done), 32'd0);
            for (int i = 0; i < LANES; i++)
               checkOutput($sformatf("rst_load_data[%0d]", i), load_data[i], 32'd0);
            repeat (2) begin
               @(negedge clk);
               checkOutput("rst_no_done", 32'(done), 32'd0);
            end
            rst_n   = 1'b1;
            stopped = 1'b1;
         end else if (done === 1'b1) begin
            doneCycle = k;
            stopped   = 1'b1;
         end
      end
      start = 1'b0;
      if (resetAt < 0) begin
         if (doneCycle < 0) begin
            checkOutput("done_timeout", 32'd1, 32'd0);
         end else begin
            @(negedge clk);
            checkOutput("done_single_cycle", 32'(done), 32'd0);
            checkOutput("idle_after_done", 32'(busy), 32'd0);
         end
      end
   endtask

   logic [3:0][31:0] sd;
   int dc, rc, bc;

   initial begin
      rst_n      = 1'b1;
      start      = 1'b0;
      is_store   = 1'b0;
      base_addr  = '0;
      stride     = '0;
      lane_mask  = '0;
      store_data = '0;
      sd         = '0;
      for (int i = 0; i < LANES; i++) modelLoad[i] = '0;
      #1 rst_n = 1'b0;
      #11;
      checkOutput("reset_mem_req", 32'(mem_req), 32'd0);
      checkOutput("reset_mem_we", 32'(mem_we), 32'd0);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_done", 32'(done), 32'd0);
      checkOutput("reset_mem_addr", mem_addr, 32'd0);
      checkOutput("reset_mem_wdata", mem_wdata, 32'd0);
      for (int i = 0; i < LANES; i++)
         checkOutput($sformatf("reset_load_data[%0d]", i), load_data[i], 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      memImage[32'h3] = 32'h5;
      memImage[32'h4] = 32'h8;
      memImage[32'h5] = 32'h12;
      memImage[32'h6] = 32'h20;

      // Full-mask load, unit stride, ack always high.
      $display("[TB] load base=0x3 stride=1 mask=1111");
      applyStimulus(1'b0, 32'h3, 32'h1, 4'b1111, sd, -1, 0, -1, -1, dc, rc, bc);
      checkOutput("t1_done_cycle", 32'(dc), 32'd5);
      checkOutput("t1_req_cycles", 32'(rc), 32'd4);
      checkOutput("t1_busy_cycles", 32'(bc), 32'd5);
      checkOutput("t1_addr0", accAddr[0], 32'h3);
      checkOutput("t1_addr3", accAddr[3], 32'h6);
      checkOutput("t1_lane0", load_data[0], 32'h5);
      checkOutput("t1_lane1", load_data[1], 32'h8);
      checkOutput("t1_lane2", load_data[2], 32'h12);
      checkOutput("t1_lane3", load_data[3], 32'h20);

      // Store with negative stride.
      $display("[TB] store base=0x100 stride=-4 mask=1111");
      sd[0] = 32'hA; sd[1] = 32'hB; sd[2] = 32'hC; sd[3] = 32'hD;
      applyStimulus(1'b1, 32'h100, 32'hFFFF_FFFC, 4'b1111, sd, -1, 0, -1, -1, dc, rc, bc);
      checkOutput("t2_done_cycle", 32'(dc), 32'd5);
      checkOutput("t2_addr0", accAddr[0], 32'h100);
      checkOutput("t2_addr1", accAddr[1], 32'hFC);
      checkOutput("t2_addr2", accAddr[2], 32'hF8);
      checkOutput("t2_addr3", accAddr[3], 32'hF4);
      checkOutput("t2_lane0_kept", load_data[0], 32'h5);
      checkOutput("t2_lane3_kept", load_data[3], 32'h20);

      // Sparse mask load.
      $display("[TB] load base=0x10 stride=2 mask=1010");
      sd = '0;
      applyStimulus(1'b0, 32'h10, 32'h2, 4'b1010, sd, -1, 0, -1, -1, dc, rc, bc);
      checkOutput("t3_done_cycle", 32'(dc), 32'd3);
      checkOutput("t3_req_cycles", 32'(rc), 32'd2);
      checkOutput("t3_addr0", accAddr[0], 32'h12);
      checkOutput("t3_addr1", accAddr[1], 32'h16);
      checkOutput("t3_lane0_kept", load_data[0], 32'h5);
      checkOutput("t3_lane1", load_data[1], 32'hA5A5_0012);
      checkOutput("t3_lane2_kept", load_data[2], 32'h12);
      checkOutput("t3_lane3", load_data[3], 32'hA5A5_0016);

      // Empty mask: no requests at all.
      $display("[TB] load mask=0000");
      applyStimulus(1'b0, 32'h40, 32'h4, 4'b0000, sd, -1, 0, -1, -1, dc, rc, bc);
      checkOutput("t4_req_cycles", 32'(rc), 32'd0);
      checkOutput("t4_done_cycle", 32'(dc), 32'd1);
      checkOutput("t4_busy_cycles", 32'(bc), 32'd1);

      // Lane 1 ack withheld for 3 cycles, with a stray start during the wait.
      $display("[TB] load base=0x40 stride=4 mask=1111, lane 1 stalled, start while busy");
      applyStimulus(1'b0, 32'h40, 32'h4, 4'b1111, sd, 1, 3, 3, -1, dc, rc, bc);
      checkOutput("t5_done_cycle", 32'(dc), 32'd8);
      checkOutput("t5_req_cycles", 32'(rc), 32'd7);
      checkOutput("t5_acks", 32'(nAcc), 32'd4);
      checkOutput("t5_addr1", accAddr[1], 32'h44);

      // Address wrap, then reset while lane 2 is outstanding.
      $display("[TB] load base=0xFFFFFFFE stride=1, reset during lane 2");
      applyStimulus(1'b0, 32'hFFFF_FFFE, 32'h1, 4'b1111, sd, -1, 0, -1, 3, dc, rc, bc);
      checkOutput("t6_addr0", accAddr[0], 32'hFFFF_FFFE);
      checkOutput("t6_addr1", accAddr[1], 32'hFFFF_FFFF);
      checkOutput("t6_addr2", accAddr[2], 32'h0);
      checkOutput("t6_done_never", 32'(dc), 32'hFFFF_FFFF);

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

   // Guard against a hung run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
